// File: rtl/qaoa_mul_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier between NUM_REQ requesters. Requester IDs
// ride a tag pipeline in lockstep with the multiplier; an unaccepted result freezes everything.
module qaoa_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = 2,
  parameter int unsigned A_WIDTH     = 49,
  parameter int unsigned B_WIDTH     = 23,
  parameter int unsigned P_WIDTH     = 68,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_WIDTH-1:0]        res_id,
  output logic [P_WIDTH-1:0]         res_data,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic [ID_WIDTH:0]          in_flight
);

  logic                                   stall;
  logic                                   found;
  logic                                   hi_found;
  logic                                   accept;
  logic [ID_WIDTH-1:0]                    hi_idx;
  logic [ID_WIDTH-1:0]                    lo_idx;
  logic [ID_WIDTH-1:0]                    grant_idx;
  logic [ID_WIDTH-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [MUL_LATENCY-1:0]                 vld_pipe_q, vld_pipe_d;
  logic [MUL_LATENCY-1:0][ID_WIDTH-1:0]   id_pipe_q, id_pipe_d;
  logic [ID_WIDTH:0]                      in_flight_q, in_flight_d;

  assign stall  = vld_pipe_q[MUL_LATENCY-1] & ~res_ready;
  assign mul_ce = ~stall;

  // Descending scan: the last hit wins, giving the lowest index at/above rr_ptr (hi) and the
  // lowest index overall (lo, used when the search wraps).
  always_comb begin
    found    = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found  = 1'b1;
        lo_idx = ID_WIDTH'(i);
        if (ID_WIDTH'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = ID_WIDTH'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  assign accept = found & mul_ce & ~reset;

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (grant_idx == ID_WIDTH'(i))) begin
        req_ready[i] = mul_ce & ~reset;
        mul_din0     = req_a[i*A_WIDTH +: A_WIDTH];
        mul_din1     = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    vld_pipe_d = vld_pipe_q;
    id_pipe_d  = id_pipe_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (mul_ce) begin
      for (int k = MUL_LATENCY - 1; k > 0; k--) begin
        vld_pipe_d[k] = vld_pipe_q[k-1];
        id_pipe_d[k]  = id_pipe_q[k-1];
      end
      vld_pipe_d[0] = accept;
      id_pipe_d[0]  = grant_idx;
    end
    // Counted from next-state so the registered count lines up with vld_pipe.
    in_flight_d = '0;
    for (int k = 0; k < MUL_LATENCY; k++) begin
      in_flight_d = in_flight_d + {{ID_WIDTH{1'b0}}, vld_pipe_d[k]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      vld_pipe_q  <= '0;
      id_pipe_q   <= '0;
      in_flight_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      vld_pipe_q  <= vld_pipe_d;
      id_pipe_q   <= id_pipe_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign res_valid = vld_pipe_q[MUL_LATENCY-1];
  assign res_id    = id_pipe_q[MUL_LATENCY-1];
  assign res_data  = mul_dout;
  assign in_flight = in_flight_q;

endmodule

// File: tb/tb_qaoa_mul_arbiter.sv
// Scoreboard bench for qaoa_mul_arbiter: a round-robin/delay-line reference predicts grants and
// results; a separate monitor checks every presented result against the expected queue.
module tb_qaoa_mul_arbiter;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int AW  = 49;
  localparam int BW  = 23;
  localparam int PW  = 68;
  localparam int LAT = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [PW-1:0] p;
  } res_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic            res_valid;
  logic            res_ready;
  logic [IW-1:0]   res_id;
  logic [PW-1:0]   res_data;
  logic            mul_ce;
  logic [AW-1:0]   mul_din0;
  logic [BW-1:0]   mul_din1;
  logic [PW-1:0]   mul_dout;
  logic [IW:0]     in_flight;

  logic [AW-1:0] a_op [N];
  logic [BW-1:0] b_op [N];

  int checks = 0;
  int errors = 0;

  res_t exp_q [$];
  bit   pipe_q [$];
  int   rr_m;

  always #5 clk = ~clk;

  qaoa_mul_arbiter #(
    .NUM_REQ(N), .ID_WIDTH(IW), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MUL_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
    .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout), .in_flight(in_flight)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = a_op[i];
      req_b[i*BW +: BW] = b_op[i];
    end
  end

  function automatic logic [PW-1:0] prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic signed [AW+BW-1:0] f;
    f = $signed({{BW{a[AW-1]}}, a}) * $signed({{AW{b[BW-1]}}, b});
    return f[PW-1:0];
  endfunction

  // Multiplier: registered inputs and registered output, shared clock enable, no reset.
  logic [AW-1:0] ma;
  logic [BW-1:0] mb;
  logic [PW-1:0] mp;
  always @(posedge clk) begin
    if (mul_ce) begin
      ma <= mul_din0;
      mb <= mul_din1;
      mp <= prod(ma, mb);
    end
  end
  assign mul_dout = mp;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    pipe_q.delete();
    for (int i = 0; i < LAT; i++) pipe_q.push_back(1'b0);
    rr_m = 0;
  endtask

  // Reference: oldest slot of the delay line sits at the back.
  bit           ev, ce, fnd;
  logic [IW-1:0] gi, ci;
  logic [N-1:0] er;
  int           cnt;
  always @(negedge clk) begin
    if (reset) begin
      check("rst_res_valid", res_valid, 0);
      check("rst_in_flight", in_flight, 0);
      check("rst_req_ready", req_ready, 0);
    end else begin
      ev  = pipe_q[LAT-1];
      ce  = !(ev && !res_ready);
      fnd = 1'b0;
      gi  = '0;
      for (int k = 0; k < N; k++) begin
        ci = IW'((rr_m + k) % N);
        if (!fnd && req_valid[ci]) begin
          fnd = 1'b1;
          gi  = ci;
        end
      end
      cnt = 0;
      foreach (pipe_q[j]) cnt += int'(pipe_q[j]);
      er = (fnd && ce) ? (N'(1) << gi) : '0;
      check("mul_ce", mul_ce, ce);
      check("req_ready", req_ready, er);
      check("res_valid", res_valid, ev);
      check("in_flight", in_flight, cnt);
      check("mul_din0", mul_din0, fnd ? a_op[gi] : '0);
      check("mul_din1", mul_din1, fnd ? b_op[gi] : '0);
      if (ce) begin
        pipe_q.push_front(fnd);
        void'(pipe_q.pop_back());
        if (fnd) begin
          exp_q.push_back('{id: gi, p: prod(a_op[gi], b_op[gi])});
          rr_m = (int'(gi) + 1) % N;
        end
      end
    end
  end

  // Monitor: compare whatever result is presented; retire it on handshake.
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id %0d data %0h, expected no result", res_id,
                 res_data);
      end else begin
        check("res_id", res_id, exp_q[0].id);
        check("res_data", res_data, exp_q[0].p);
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 7))
        0:       a_op[i] = {1'b1, {(AW-1){1'b0}}};
        1:       a_op[i] = {1'b0, {(AW-1){1'b1}}};
        default: a_op[i] = AW'({$urandom(), $urandom()});
      endcase
      case ($urandom_range(0, 7))
        0:       b_op[i] = {1'b1, {(BW-1){1'b0}}};
        1:       b_op[i] = {1'b0, {(BW-1){1'b1}}};
        default: b_op[i] = BW'($urandom());
      endcase
    end
  endtask

  // Inputs change just after a rising edge and hold for one full cycle.
  task automatic step(input logic [N-1:0] v, input logic rr, input bit rnd);
    if (rnd) rand_ops();
    req_valid = v;
    res_ready = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_model();
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    req_valid = '1;
    res_ready = 1'b1;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single op: -3 * 7 from requester 0.
    a_op[0] = AW'(-3);
    b_op[0] = BW'(7);
    step(4'b0001, 1'b1, 1'b0);
    repeat (4) step(4'b0000, 1'b1, 1'b0);

    // Fairness: everyone requesting.
    repeat (12) step(4'b1111, 1'b1, 1'b1);
    repeat (3) step(4'b0000, 1'b1, 1'b0);

    // Backpressure with requesters holding valid through the stall.
    repeat (2) step(4'b1111, 1'b1, 1'b1);
    repeat (4) step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    repeat (4) step(4'b0000, 1'b1, 1'b0);

    // Skip and wrap: pointer lands on 3, then only 0 and 2 request.
    step(4'b0100, 1'b1, 1'b1);
    repeat (3) step(4'b0101, 1'b1, 1'b1);
    repeat (3) step(4'b0000, 1'b1, 1'b0);

    // Extremes.
    a_op[0] = {1'b1, {(AW-1){1'b0}}};
    b_op[0] = {1'b1, {(BW-1){1'b0}}};
    step(4'b0001, 1'b1, 1'b0);
    a_op[0] = {1'b0, {(AW-1){1'b1}}};
    b_op[0] = {1'b0, {(BW-1){1'b1}}};
    step(4'b0001, 1'b1, 1'b0);
    a_op[0] = {1'b1, {(AW-1){1'b0}}};
    step(4'b0001, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 1'b1, 1'b0);

    // Random traffic with random backpressure.
    repeat (300) step(N'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, 1'b1);
    repeat (4) step(4'b0000, 1'b1, 1'b0);

    // Reset mid-flight with two ops in the pipe.
    repeat (2) step(4'b0011, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_res_valid", res_valid, 0);
    check("async_rst_in_flight", in_flight, 0);
    clear_model();
    req_valid = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) step(4'b1111, 1'b1, 1'b1);

    repeat (8) step(4'b0000, 1'b1, 1'b0);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
